// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings and the issue-slot entry layout.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 5;
  localparam int SHAMT_W    = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SLL = 3'b011;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            ctl;
    logic [CPU_DATA_W-1:0] a;
    logic [CPU_DATA_W-1:0] b;
    logic [SHAMT_W-1:0]    shamt;
    logic [CPU_REG_AW-1:0] rs;
    logic [CPU_REG_AW-1:0] rt;
    logic                  wr_en;
    logic [CPU_REG_AW-1:0] wr_reg;
  } issue_entry_t;

endpackage

// File: rtl/ex_issue_stage_operand_snoop.sv
// Per-operand result-bus snoop: replaces a value whose source register is being
// written by EX/MEM (preferred) or WB. Register 0 is never replaced.
module operand_snoop #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] tag,
  input  logic [DATA_W-1:0] value,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_wr_reg,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = value;
    if (tag != '0) begin
      if (exm_wr_en && exm_wr_reg == tag) begin
        result = exm_result;
      end else if (wb_wr_en && wb_wr_reg == tag) begin
        result = wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Registered ID->EX boundary with a two-entry skid buffer (main + skid).
// Define EX_ISSUE_FWD_EN to snoop the EX/MEM and WB buses into held operands.
module ex_issue_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ctl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [4:0]        in_shamt,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic              in_wr_en,
  input  logic [REG_AW-1:0] in_wr_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        ctl,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        shamt,
  output logic              out_wr_en,
  output logic [REG_AW-1:0] out_wr_reg,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_wr_reg,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_reg,
  input  logic [DATA_W-1:0] wb_data
);

  // Slot layout lives in the shared package, so widths must agree with it.
  generate
    if (DATA_W != CPU_DATA_W || REG_AW != CPU_REG_AW) begin : g_bad_cfg
      $error("ex_issue_stage: DATA_W/REG_AW must match cpu_pkg widths");
    end
  endgenerate

  issue_entry_t main_reg, main_next;
  issue_entry_t skid_reg, skid_next;
  issue_entry_t in_entry;
  issue_entry_t in_s, main_s, skid_s;
  issue_entry_t src [3];
  logic [DATA_W-1:0] a_snp [3];
  logic [DATA_W-1:0] b_snp [3];
  logic in_ready_reg;
  logic accept, xfer;

  always_comb begin
    in_entry        = '0;
    in_entry.valid  = 1'b1;
    in_entry.ctl    = in_ctl;
    in_entry.a      = in_a;
    in_entry.b      = in_b;
    in_entry.shamt  = in_shamt;
    in_entry.rs     = in_rs;
    in_entry.rt     = in_rt;
    in_entry.wr_en  = in_wr_en;
    in_entry.wr_reg = in_wr_reg;
  end

  assign src[0] = in_entry;
  assign src[1] = main_reg;
  assign src[2] = skid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_snoop
`ifdef EX_ISSUE_FWD_EN
      operand_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_snoop_a (
        .tag(src[gi].rs), .value(src[gi].a),
        .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_result(exm_result),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
        .result(a_snp[gi])
      );
      operand_snoop #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_snoop_b (
        .tag(src[gi].rt), .value(src[gi].b),
        .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_result(exm_result),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data),
        .result(b_snp[gi])
      );
`else
      assign a_snp[gi] = src[gi].a;
      assign b_snp[gi] = src[gi].b;
`endif
    end
  endgenerate

`ifndef EX_ISSUE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{exm_wr_en, exm_wr_reg, exm_result, wb_wr_en, wb_wr_reg, wb_data};
`endif

  always_comb begin
    in_s     = in_entry;
    in_s.a   = a_snp[0];
    in_s.b   = b_snp[0];
    main_s   = main_reg;
    main_s.a = a_snp[1];
    main_s.b = b_snp[1];
    skid_s   = skid_reg;
    skid_s.a = a_snp[2];
    skid_s.b = b_snp[2];
  end

  assign accept = in_valid && in_ready_reg;
  assign xfer   = main_reg.valid && out_ready;

  always_comb begin
    main_next = main_s;
    skid_next = skid_s;
    if (xfer) begin
      if (skid_reg.valid) begin
        main_next = skid_s;
        skid_next = accept ? in_s : '0;
      end else begin
        main_next = accept ? in_s : '0;
      end
    end else if (!main_reg.valid) begin
      main_next = accept ? in_s : '0;
    end else if (accept) begin
      skid_next = in_s;
    end
    if (flush) begin
      main_next = '0;
      skid_next = '0;
    end
    // Zero an empty main slot so the ALU-facing outputs read 0 when idle.
    if (!main_next.valid) begin
      main_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= !skid_next.valid;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = main_reg.valid;
  assign ctl        = main_reg.ctl;
  assign a          = main_reg.a;
  assign b          = main_reg.b;
  assign shamt      = main_reg.shamt;
  assign out_wr_en  = main_reg.wr_en;
  assign out_wr_reg = main_reg.wr_reg;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: expected ops are queued at issue time and
// a negedge monitor checks every transfer; direct checks cover reset/flush/stall.
module tb_ex_issue_stage;
  import cpu_pkg::*;

`ifdef EX_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctl;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_shamt, in_rs, in_rt, in_wr_reg;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid, out_ready;
  logic [2:0]  ctl;
  logic [31:0] a, b;
  logic [4:0]  shamt, out_wr_reg;
  logic        out_wr_en;
  logic        exm_wr_en, wb_wr_en;
  logic [4:0]  exm_wr_reg, wb_wr_reg;
  logic [31:0] exm_result, wb_data;

  ex_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctl(in_ctl), .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
    .in_rs(in_rs), .in_rt(in_rt), .in_wr_en(in_wr_en), .in_wr_reg(in_wr_reg),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ctl(ctl), .a(a), .b(b), .shamt(shamt),
    .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg),
    .exm_wr_en(exm_wr_en), .exm_wr_reg(exm_wr_reg), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        wr_en;
    logic [4:0]  wr_reg;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [31:0] av, input logic [31:0] bv,
                      input logic [4:0] sh, input logic wre, input logic [4:0] wrr);
    exp_t e;
    e.ctl = c; e.a = av; e.b = bv; e.shamt = sh; e.wr_en = wre; e.wr_reg = wrr;
    sb.push_back(e);
  endtask

  // Drive one op and hold it until the edge at which it is accepted.
  task automatic issue(input logic [2:0] c, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                       input logic wre, input logic [4:0] wrr);
    bit done = 1'b0;
    in_ctl = c; in_a = av; in_b = bv; in_shamt = sh;
    in_rs = rs; in_rt = rt; in_wr_en = wre; in_wr_reg = wrr;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: ctl=%0h a=%0h b=%0h with empty scoreboard", ctl, a, b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({ctl, a, b, shamt, out_wr_en, out_wr_reg} !== {e.ctl, e.a, e.b, e.shamt, e.wr_en, e.wr_reg}) begin
          errors++;
          $display("FAIL xfer_data: got ctl=%0h a=%0h b=%0h sh=%0h we=%0b wr=%0h expected ctl=%0h a=%0h b=%0h sh=%0h we=%0b wr=%0h",
                   ctl, a, b, shamt, out_wr_en, out_wr_reg, e.ctl, e.a, e.b, e.shamt, e.wr_en, e.wr_reg);
        end else begin
          $display("xfer ctl=%0h a=%0h b=%0h wr=%0h ok", ctl, a, b, out_wr_reg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea, eb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_ctl = '0; in_a = '0; in_b = '0; in_shamt = '0; in_rs = '0; in_rt = '0;
    in_wr_en = 1'b0; in_wr_reg = '0;
    exm_wr_en = 1'b0; exm_wr_reg = '0; exm_result = '0;
    wb_wr_en = 1'b0; wb_wr_reg = '0; wb_data = '0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_data", {27'd0, ctl, a}, 64'd0);
    rst = 1'b0;
    tick();
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // Single op with 1-cycle latency
    out_ready = 1'b1;
    push(ALU_ADD, 32'd5, 32'd7, 5'd0, 1'b1, 5'd3);
    issue(ALU_ADD, 32'd5, 32'd7, 5'd0, 5'd1, 5'd2, 1'b1, 5'd3);
    idle();
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_ctl", 64'(ctl), 64'(ALU_ADD));
    tick();
    check("single_gone", 64'(out_valid), 64'd0);
    check("idle_zero", {a, b}, 64'd0);

    // Backpressure: two held, third stalled until skid frees
    out_ready = 1'b0;
    push(ALU_OR,  32'h11, 32'h12, 5'd0, 1'b1, 5'd10);
    push(ALU_SUB, 32'h21, 32'h22, 5'd0, 1'b0, 5'd11);
    push(ALU_SLL, 32'h31, 32'h32, 5'd4, 1'b1, 5'd12);
    issue(ALU_OR,  32'h11, 32'h12, 5'd0, 5'd1, 5'd2, 1'b1, 5'd10);
    issue(ALU_SUB, 32'h21, 32'h22, 5'd0, 5'd1, 5'd2, 1'b0, 5'd11);
    in_ctl = ALU_SLL; in_a = 32'h31; in_b = 32'h32; in_shamt = 5'd4; in_wr_en = 1'b1; in_wr_reg = 5'd12;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_still_full", 64'(in_ready), 64'd0);
    check("bp_stable", {31'd0, out_valid, 29'd0, ctl}, {31'd0, 1'b1, 29'd0, ALU_OR});
    out_ready = 1'b1;
    issue(ALU_SLL, 32'h31, 32'h32, 5'd4, 5'd1, 5'd2, 1'b1, 5'd12);
    idle();
    repeat (3) tick();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Snoop: EX/MEM priority, WB fallback, register 0 untouched
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd1, 32'd2, 5'd0, 5'd4, 5'd6, 1'b1, 5'd7);
    idle();
    exm_wr_en = 1'b1; exm_wr_reg = 5'd4; exm_result = 32'hAA;
    wb_wr_en = 1'b1; wb_wr_reg = 5'd4; wb_data = 32'hBB;
    tick();
    ea = FWD ? 32'hAA : 32'd1;
    check("fwd_priority_a", 64'(a), 64'(ea));
    exm_wr_reg = 5'd9; wb_wr_reg = 5'd6; wb_data = 32'h77;
    tick();
    eb = FWD ? 32'h77 : 32'd2;
    check("fwd_wb_b", 64'(b), 64'(eb));
    exm_wr_en = 1'b0; wb_wr_en = 1'b0;
    push(ALU_ADD, ea, eb, 5'd0, 1'b1, 5'd7);
    issue(ALU_AND, 32'd3, 32'd9, 5'd0, 5'd5, 5'd0, 1'b0, 5'd8);
    idle();
    exm_wr_en = 1'b1; exm_wr_reg = 5'd0; exm_result = 32'h55;
    wb_wr_en = 1'b1; wb_wr_reg = 5'd5; wb_data = 32'h44;
    tick();
    exm_wr_en = 1'b0; wb_wr_en = 1'b0;
    check("fwd_main_kept", 64'(a), 64'(ea));
    push(ALU_AND, FWD ? 32'h44 : 32'd3, 32'd9, 5'd0, 1'b0, 5'd8);
    out_ready = 1'b1;
    repeat (3) tick();

    // Snoop at capture
    exm_wr_en = 1'b1; exm_wr_reg = 5'd8; exm_result = 32'h99;
    push(ALU_SLT, FWD ? 32'h99 : 32'h10, FWD ? 32'h99 : 32'h20, 5'd0, 1'b1, 5'd1);
    issue(ALU_SLT, 32'h10, 32'h20, 5'd0, 5'd8, 5'd8, 1'b1, 5'd1);
    idle();
    exm_wr_en = 1'b0;
    repeat (2) tick();
    check("fwd_drained", 64'(sb.size()), 64'd0);

    // Flush with both slots full and in_valid high
    out_ready = 1'b0;
    issue(ALU_OR, 32'hA1, 32'hA2, 5'd0, 5'd1, 5'd2, 1'b1, 5'd1);
    issue(ALU_OR, 32'hB1, 32'hB2, 5'd0, 5'd1, 5'd2, 1'b1, 5'd2);
    in_valid = 1'b1; in_a = 32'hC1; flush = 1'b1;
    tick();
    flush = 1'b0; idle();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    // Flush while an accept would otherwise land
    issue(ALU_OR, 32'hD1, 32'hD2, 5'd0, 5'd1, 5'd2, 1'b1, 5'd3);
    in_valid = 1'b1; in_a = 32'hE1; flush = 1'b1;
    tick();
    flush = 1'b0; idle();
    check("flush_accept", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-stream
    out_ready = 1'b0;
    issue(ALU_SUB, 32'h5A, 32'hA5, 5'd2, 5'd1, 5'd2, 1'b1, 5'd9);
    idle();
    check("mid_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_outputs", {26'd0, out_valid, ctl, a, out_wr_en, out_wr_reg}, 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("mid_release_ready", 64'(in_ready), 64'd1);

    // Back-to-back throughput
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("tput_ready", 64'(in_ready), 64'd1);
      push(ALU_ADD, 32'(100 + i), 32'(200 + i), 5'(i), 1'b1, 5'(20 + i));
      issue(ALU_ADD, 32'(100 + i), 32'(200 + i), 5'(i), 5'd1, 5'd2, 1'b1, 5'(20 + i));
    end
    idle();
    repeat (3) tick();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
